// File: rtl/axis_tp_pkg.sv
// Shared definitions for the AXIS test-pattern generator/checker pair.
// Holds the two-state FSM encoding and the counter wrap rule used by both ends.
// Purely combinational content; no latency or backpressure of its own.
package axis_tp_pkg;

    typedef logic [0:0] tp_state_t;

    localparam tp_state_t HUNT = 1'b0;
    localparam tp_state_t LOCK = 1'b1;

    // Arithmetic is carried at 64 bits signed so that stop-incr+1 and the wrap
    // offset never overflow for any beat width up to 64.
    function automatic logic signed [63:0] tp_next(
        input logic signed [63:0] x,
        input logic signed [63:0] start,
        input logic signed [63:0] stop,
        input logic signed [63:0] incr
    );
        if (x >= stop - incr + 64'sd1) begin
            return x + incr - (stop - start) - 64'sd1;
        end
        return x + incr;
    endfunction

endpackage

// File: rtl/axis_tp_ready_throttle.sv
// Periodic ready mask: low for one cycle out of every READY_DIVIDER.
// Free-running, no input dependency; mask is a registered-counter decode.
// Produces backpressure only; never consumes any.
module axis_tp_ready_throttle #(
    parameter int READY_DIVIDER = 8
) (
    input  logic m_axis_aclk,
    input  logic m_axis_aresetn,
    output logic ready_mask
);

    localparam int DIV_W = (READY_DIVIDER > 1) ? $clog2(READY_DIVIDER) : 1;
    localparam logic [DIV_W-1:0] RELOAD = DIV_W'(READY_DIVIDER - 1);

    logic [DIV_W-1:0] div_cnt;

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            div_cnt <= RELOAD;
        end else if (div_cnt == '0) begin
            div_cnt <= RELOAD;
        end else begin
            div_cnt <= div_cnt - DIV_W'(1);
        end
    end

    assign ready_mask = (div_cnt != '0);

endmodule

// File: rtl/axis_testpattern_checker.sv
// AXIS sink that locks onto a wrapping counter stream and counts mismatches.
// Status updates on the accepting edge (visible next cycle); tready = enable delayed 1.
// Throttled tready under AXIS_TPCHK_BACKPRESSURE_EN; otherwise backpressure only via enable.
module axis_testpattern_checker
    import axis_tp_pkg::*;
#(
    parameter int S_AXIS_TDATA_WIDTH = 32,
    parameter int COUNTER_START      = 0,
    parameter int COUNTER_END        = 255,
    parameter int COUNTER_INCR       = 1,
    parameter int LOSS_THRESHOLD     = 4,
    parameter int CNT_WIDTH          = 32,
    parameter int READY_DIVIDER      = 8
) (
    input  logic                          m_axis_aclk,
    input  logic                          m_axis_aresetn,
    input  logic                          enable,
    input  logic                          clear_counters,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic                          locked,
    output logic                          error_pulse,
    output logic [CNT_WIDTH-1:0]          error_count,
    output logic [CNT_WIDTH-1:0]          word_count,
    output logic [S_AXIS_TDATA_WIDTH-1:0] last_bad_data,
    output logic [S_AXIS_TDATA_WIDTH-1:0] expected_data
);

    localparam int     MISS_W  = $clog2(LOSS_THRESHOLD + 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_THRESHOLD - 1);
    localparam longint P_START = longint'(COUNTER_START);
    localparam longint P_END   = longint'(COUNTER_END);
    localparam longint P_INCR  = longint'(COUNTER_INCR);

    if (LOSS_THRESHOLD < 1) begin : g_bad_threshold
        $error("LOSS_THRESHOLD must be at least 1");
    end
    if (READY_DIVIDER < 1) begin : g_bad_divider
        $error("READY_DIVIDER must be at least 1");
    end

    tp_state_t                    state;
    logic [MISS_W-1:0]            miss_cnt;
    logic                         enable_q;
    logic                         beat;
    logic                         in_range;
    logic                         match;
    logic signed [63:0]           data_sx;
    logic [S_AXIS_TDATA_WIDTH-1:0] next_of_data;
    logic [S_AXIS_TDATA_WIDTH-1:0] next_of_exp;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign data_sx      = 64'(signed'(s_axis_tdata));
    assign in_range     = (data_sx >= P_START) && (data_sx <= P_END);
    assign match        = (s_axis_tdata == expected_data);
    assign next_of_data = S_AXIS_TDATA_WIDTH'(tp_next(data_sx, P_START, P_END, P_INCR));
    assign next_of_exp  = S_AXIS_TDATA_WIDTH'(tp_next(64'(signed'(expected_data)),
                                                      P_START, P_END, P_INCR));
    assign beat         = s_axis_tvalid & s_axis_tready;
    assign locked       = (state == LOCK);

`ifdef AXIS_TPCHK_BACKPRESSURE_EN
    logic ready_mask;

    axis_tp_ready_throttle #(
        .READY_DIVIDER (READY_DIVIDER)
    ) u_throttle (
        .m_axis_aclk    (m_axis_aclk),
        .m_axis_aresetn (m_axis_aresetn),
        .ready_mask     (ready_mask)
    );

    assign s_axis_tready = enable_q & ready_mask;
`else
    assign s_axis_tready = enable_q;
`endif

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            enable_q      <= 1'b0;
            state         <= HUNT;
            miss_cnt      <= '0;
            error_pulse   <= 1'b0;
            error_count   <= '0;
            word_count    <= '0;
            last_bad_data <= '0;
            expected_data <= S_AXIS_TDATA_WIDTH'(COUNTER_START);
        end else begin
            enable_q    <= enable;
            error_pulse <= 1'b0;
            if (beat) begin
                if (state == HUNT) begin
                    if (in_range) begin
                        expected_data <= next_of_data;
                        state         <= LOCK;
                    end
                end else begin
                    // Expected keeps free-running so a single slip does not reseed it.
                    expected_data <= next_of_exp;
                    word_count    <= sat_inc(word_count);
                    if (match) begin
                        miss_cnt <= '0;
                    end else begin
                        error_pulse   <= 1'b1;
                        last_bad_data <= s_axis_tdata;
                        error_count   <= sat_inc(error_count);
                        if (miss_cnt == MISS_LAST) begin
                            state    <= HUNT;
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_cnt + MISS_W'(1);
                        end
                    end
                end
            end
            // Clear overrides any increment from a beat in the same cycle.
            if (clear_counters) begin
                error_count <= '0;
                word_count  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_axis_testpattern_checker.sv
// Self-checking bench: two checker instances (default and 10..20 step 3 with 4-bit counters).
module tb_axis_testpattern_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        en_a, clr_a, vld_a, rdy_a, lck_a, pls_a;
    logic [31:0] dat_a, ec_a, wc_a, lbd_a, exp_a;
    logic        en_b, clr_b, vld_b, rdy_b, lck_b, pls_b;
    logic [31:0] dat_b, lbd_b, exp_b;
    logic [3:0]  ec_b, wc_b;

    axis_testpattern_checker u_dut_a (
        .m_axis_aclk(clk), .m_axis_aresetn(rstn), .enable(en_a), .clear_counters(clr_a),
        .s_axis_tdata(dat_a), .s_axis_tvalid(vld_a), .s_axis_tready(rdy_a),
        .locked(lck_a), .error_pulse(pls_a), .error_count(ec_a), .word_count(wc_a),
        .last_bad_data(lbd_a), .expected_data(exp_a)
    );

    axis_testpattern_checker #(
        .COUNTER_START(10), .COUNTER_END(20), .COUNTER_INCR(3), .CNT_WIDTH(4)
    ) u_dut_b (
        .m_axis_aclk(clk), .m_axis_aresetn(rstn), .enable(en_b), .clear_counters(clr_b),
        .s_axis_tdata(dat_b), .s_axis_tvalid(vld_b), .s_axis_tready(rdy_b),
        .locked(lck_b), .error_pulse(pls_b), .error_count(ec_b), .word_count(wc_b),
        .last_bad_data(lbd_b), .expected_data(exp_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, one slot per instance.
    longint      c_st[2], c_en[2], c_inc[2], c_max[2];
    bit          m_lock[2], m_pulse[2];
    longint      m_exp[2], m_err[2], m_words[2];
    int          m_miss[2];
    logic [31:0] m_last[2];

    function automatic longint ref_next(int s, longint x);
        longint r;
        int     t;
        if (x >= c_en[s] - c_inc[s] + 1) r = x + c_inc[s] - (c_en[s] - c_st[s]) - 1;
        else                             r = x + c_inc[s];
        t = int'(r);
        return longint'(t);
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_lock[s] = 0; m_pulse[s] = 0; m_exp[s] = c_st[s];
            m_err[s] = 0; m_words[s] = 0; m_miss[s] = 0; m_last[s] = '0;
        end
    endtask

    task automatic model_cycle(int s, bit beat, logic [31:0] d, bit clr);
        longint x;
        x = longint'(int'(d));
        m_pulse[s] = 0;
        if (beat) begin
            if (!m_lock[s]) begin
                if (x >= c_st[s] && x <= c_en[s]) begin
                    m_exp[s]  = ref_next(s, x);
                    m_lock[s] = 1;
                end
            end else begin
                bit bad;
                bad        = (x != m_exp[s]);
                m_exp[s]   = ref_next(s, m_exp[s]);
                m_words[s] = (m_words[s] + 1 > c_max[s]) ? c_max[s] : m_words[s] + 1;
                if (bad) begin
                    m_pulse[s] = 1;
                    m_last[s]  = d;
                    m_err[s]   = (m_err[s] + 1 > c_max[s]) ? c_max[s] : m_err[s] + 1;
                    m_miss[s]++;
                    if (m_miss[s] >= 4) begin
                        m_lock[s] = 0;
                        m_miss[s] = 0;
                    end
                end else begin
                    m_miss[s] = 0;
                end
            end
        end
        if (clr) begin
            m_err[s]   = 0;
            m_words[s] = 0;
        end
    endtask

    function automatic bit rdy_of(int s);
        return (s == 0) ? rdy_a : rdy_b;
    endfunction

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(int s, logic [31:0] d, bit clr);
        int w = 0;
        if (s == 0) begin dat_a = d; vld_a = 1; clr_a = clr; end
        else        begin dat_b = d; vld_b = 1; clr_b = clr; end
        while (rdy_of(s) !== 1'b1 && w < 50) begin
            @(posedge clk);
            model_cycle(s, 0, d, clr);
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            n_checks++; n_fail++;
            $display("FAIL ready_timeout inst=%0d: tready never rose, required 1", s);
        end
        @(posedge clk);
        model_cycle(s, 1, d, clr);
        @(negedge clk);
        if (s == 0) begin vld_a = 0; clr_a = 0; end
        else        begin vld_b = 0; clr_b = 0; end
    endtask

    task automatic test_reset();
        rstn = 0; en_a = 0; en_b = 0; clr_a = 0; clr_b = 0; vld_a = 0; vld_b = 0;
        dat_a = '0; dat_b = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1;
        @(negedge clk);
        n_checks += 8;
        if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL reset_tready got %0b want 0", rdy_a); end
        if (lck_a !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %0b want 0", lck_a); end
        if (pls_a !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %0b want 0", pls_a); end
        if (ec_a !== 32'd0) begin n_fail++; $display("FAIL reset_errcnt got %0d want 0", ec_a); end
        if (wc_a !== 32'd0) begin n_fail++; $display("FAIL reset_wordcnt got %0d want 0", wc_a); end
        if (lbd_a !== 32'd0) begin n_fail++; $display("FAIL reset_lastbad got %0d want 0", lbd_a); end
        if (exp_a !== 32'd0) begin n_fail++; $display("FAIL reset_expected_a got %0d want 0", exp_a); end
        if (exp_b !== 32'd10) begin n_fail++; $display("FAIL reset_expected_b got %0d want 10", exp_b); end
        en_a = 1; en_b = 1;
        #1;
        n_checks++;
        if (rdy_a !== 1'b0) begin n_fail++; $display("FAIL tready_early got %0b want 0", rdy_a); end
        @(negedge clk);
`ifndef AXIS_TPCHK_BACKPRESSURE_EN
        n_checks++;
        if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL tready_delay got %0b want 1", rdy_a); end
`endif
    endtask

    task automatic test_sequence();
        send(0, 32'd0, 0);
        n_checks++;
        if (lck_a !== 1'b1) begin n_fail++; $display("FAIL lock_first_beat got %0b want 1", lck_a); end
        for (int i = 1; i < 256; i++) send(0, 32'(i), 0);
        send(0, 32'd0, 0);
        send(0, 32'd1, 0);
        n_checks += 3;
        if (ec_a !== 32'd0)   begin n_fail++; $display("FAIL seq_errcnt got %0d want 0", ec_a); end
        if (wc_a !== 32'd257) begin n_fail++; $display("FAIL seq_wordcnt got %0d want 257", wc_a); end
        if (exp_a !== 32'd2)  begin n_fail++; $display("FAIL seq_expected got %0d want 2", exp_a); end
    endtask

    task automatic test_single_error();
        logic [31:0] vals [8] = '{2, 3, 4, 5, 6, 99, 8, 9};
        for (int i = 0; i < 8; i++) begin
            send(0, vals[i], 0);
            n_checks++;
            if (pls_a !== (vals[i] == 32'd99)) begin
                n_fail++; $display("FAIL err_pulse beat=%0d got %0b want %0b", vals[i], pls_a, vals[i] == 32'd99);
            end
        end
        n_checks += 3;
        if (ec_a !== 32'd1)   begin n_fail++; $display("FAIL single_errcnt got %0d want 1", ec_a); end
        if (lbd_a !== 32'd99) begin n_fail++; $display("FAIL single_lastbad got %0d want 99", lbd_a); end
        if (lck_a !== 1'b1)   begin n_fail++; $display("FAIL single_lock got %0b want 1", lck_a); end
    endtask

    task automatic test_loss();
        for (int i = 0; i < 4; i++) begin
            send(0, 32'(1000 + i), 0);
            n_checks++;
            if (lck_a !== (i < 3)) begin
                n_fail++; $display("FAIL loss_lock miss=%0d got %0b want %0b", i + 1, lck_a, i < 3);
            end
        end
        send(0, 32'd17, 0);
        n_checks += 2;
        if (lck_a !== 1'b1)   begin n_fail++; $display("FAIL relock got %0b want 1", lck_a); end
        if (exp_a !== 32'd18) begin n_fail++; $display("FAIL relock_expected got %0d want 18", exp_a); end
    endtask

    task automatic test_wrap();
        logic [31:0] vals [4] = '{16, 19, 11, 14};
        for (int i = 0; i < 4; i++) send(1, vals[i], 0);
        n_checks += 3;
        if (ec_b !== 4'd0)   begin n_fail++; $display("FAIL wrap_errcnt got %0d want 0", ec_b); end
        if (wc_b !== 4'd3)   begin n_fail++; $display("FAIL wrap_wordcnt got %0d want 3", wc_b); end
        if (exp_b !== 32'd17) begin n_fail++; $display("FAIL wrap_expected got %0d want 17", exp_b); end
    endtask

    task automatic test_clear();
        send(0, 32'd500, 1);
        n_checks += 3;
        if (pls_a !== 1'b1) begin n_fail++; $display("FAIL clear_pulse got %0b want 1", pls_a); end
        if (ec_a !== 32'd0) begin n_fail++; $display("FAIL clear_errcnt got %0d want 0", ec_a); end
        if (wc_a !== 32'd0) begin n_fail++; $display("FAIL clear_wordcnt got %0d want 0", wc_a); end
        send(0, 32'd600, 0);
        send(0, 32'(m_exp[0]), 0);
        clr_a = 1;
        @(posedge clk);
        model_cycle(0, 0, '0, 1);
        @(negedge clk);
        clr_a = 0;
        n_checks += 2;
        if (ec_a !== 32'd0) begin n_fail++; $display("FAIL idle_clear_errcnt got %0d want 0", ec_a); end
        if (pls_a !== 1'b0) begin n_fail++; $display("FAIL idle_pulse got %0b want 0", pls_a); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            send(1, 32'd999, 0);
            send(1, 32'(m_exp[1]), 0);
        end
        n_checks += 3;
        if (ec_b !== 4'hF) begin n_fail++; $display("FAIL sat_errcnt got %0d want 15", ec_b); end
        if (wc_b !== 4'hF) begin n_fail++; $display("FAIL sat_wordcnt got %0d want 15", wc_b); end
        if (ec_b !== 4'(m_err[1])) begin n_fail++; $display("FAIL sat_model got %0d want %0d", ec_b, m_err[1]); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            int r;
            r = $urandom_range(0, 9);
            if (r < 6)      d = 32'(m_exp[0]);
            else if (r < 8) d = 32'($urandom_range(0, 255));
            else            d = $urandom;
            send(0, d, $urandom_range(0, 31) == 0);
            n_checks++;
            if (lck_a !== m_lock[0] || pls_a !== m_pulse[0] || ec_a !== 32'(m_err[0]) ||
                wc_a !== 32'(m_words[0]) || lbd_a !== m_last[0] || exp_a !== 32'(m_exp[0])) begin
                n_fail++;
                $display("FAIL random beat=%0d data=%0h got lck=%0b pls=%0b ec=%0d wc=%0d lbd=%0h exp=%0h want lck=%0b pls=%0b ec=%0d wc=%0d lbd=%0h exp=%0h",
                         i, d, lck_a, pls_a, ec_a, wc_a, lbd_a, exp_a, m_lock[0], m_pulse[0],
                         m_err[0], m_words[0], m_last[0], 32'(m_exp[0]));
            end
        end
    endtask

    task automatic test_throttle();
        int lows = 0;
        int want;
`ifdef AXIS_TPCHK_BACKPRESSURE_EN
        want = 8;
`else
        want = 0;
`endif
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (rdy_a !== 1'b1) lows++;
        end
        n_checks++;
        if (lows != want) begin n_fail++; $display("FAIL throttle_lows got %0d want %0d", lows, want); end
        send(0, 32'd40, 0);
        for (int i = 0; i < 60; i++) send(0, 32'(m_exp[0]), 0);
        n_checks += 2;
        if (ec_a !== 32'(m_err[0])) begin n_fail++; $display("FAIL throttle_errcnt got %0d want %0d", ec_a, m_err[0]); end
        if (lck_a !== 1'b1) begin n_fail++; $display("FAIL throttle_lock got %0b want 1", lck_a); end
    endtask

    task automatic test_async_reset();
        #2;
        rstn = 0;
        model_reset();
        #1;
        n_checks += 6;
        if (rdy_a !== 1'b0)  begin n_fail++; $display("FAIL arst_tready got %0b want 0", rdy_a); end
        if (lck_a !== 1'b0)  begin n_fail++; $display("FAIL arst_locked got %0b want 0", lck_a); end
        if (ec_a !== 32'd0)  begin n_fail++; $display("FAIL arst_errcnt got %0d want 0", ec_a); end
        if (wc_a !== 32'd0)  begin n_fail++; $display("FAIL arst_wordcnt got %0d want 0", wc_a); end
        if (exp_a !== 32'd0) begin n_fail++; $display("FAIL arst_expected got %0d want 0", exp_a); end
        if (lbd_a !== 32'd0) begin n_fail++; $display("FAIL arst_lastbad got %0d want 0", lbd_a); end
        @(negedge clk);
        rstn = 1;
        send(0, 32'd300, 0);
        send(0, 32'd5, 0);
        n_checks += 3;
        if (lck_a !== 1'b1)  begin n_fail++; $display("FAIL rehunt_lock got %0b want 1", lck_a); end
        if (exp_a !== 32'd6) begin n_fail++; $display("FAIL rehunt_expected got %0d want 6", exp_a); end
        if (wc_a !== 32'd0)  begin n_fail++; $display("FAIL rehunt_wordcnt got %0d want 0", wc_a); end
    endtask

    initial begin
        c_st  = '{0, 10};
        c_en  = '{255, 20};
        c_inc = '{1, 3};
        c_max = '{64'd4294967295, 64'd15};
        test_reset();
        test_sequence();
        test_single_error();
        test_loss();
        test_wrap();
        test_clear();
        test_saturation();
        test_random();
        test_throttle();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
